// File: rtl/dffq_scan_pipe_if.sv
// Bundle of functional, scan and output signals for dffq_scan_pipe.
// The master drives the pipeline; the slave is the pipeline itself.
interface dffq_scan_pipe_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             clr;
  logic             vi;
  logic [WIDTH-1:0] d;
  logic             se;
  logic             si;
  logic [WIDTH-1:0] q;
  logic             vo;
  logic             so;

  modport master (
    output en, clr, vi, d, se, si,
    input  q, vo, so
  );

  modport slave (
    input  en, clr, vi, d, se, si,
    output q, vo, so
  );
endinterface

// File: rtl/dffq_scan_pipe.sv
// STAGES-deep WIDTH-bit register pipeline with per-stage valid, clock enable,
// synchronous valid-clear and a scan chain threading every data and valid bit.
module dffq_scan_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  dffq_scan_pipe_if.slave    bus
);

  logic [STAGES-1:0][WIDTH-1:0] data, data_nxt;
  logic [STAGES-1:0]            vld,  vld_nxt;

  // NOTE: combinational next-state uses blocking '=' and assigns every output
  // a default first, so the tools never infer a latch for an unlisted branch.
  always_comb begin
    data_nxt = data;
    vld_nxt  = vld;
    if (bus.se) begin
      // Chain: si -> data[0][0..W-1] -> vld[0] -> data[1][0..] -> ... -> vld[last]
      data_nxt[0][0] = bus.si;
      for (int k = 1; k < STAGES; k++) data_nxt[k][0] = vld[k-1];
      for (int k = 0; k < STAGES; k++) begin
        for (int i = 1; i < WIDTH; i++) data_nxt[k][i] = data[k][i-1];
        vld_nxt[k] = data[k][WIDTH-1];
      end
    end else begin
      if (bus.en) begin
        data_nxt[0] = bus.d;
        vld_nxt[0]  = bus.vi;
        for (int k = 1; k < STAGES; k++) begin
          data_nxt[k] = data[k-1];
          vld_nxt[k]  = vld[k-1];
        end
      end
      // Clear only kills valids; data still advances with en.
      if (bus.clr) vld_nxt = '0;
    end
  end

  // NOTE: state registers use non-blocking '<='; these are individual flops
  // (not a RAM array), so every stage is reset, data to RESET_VAL and valid to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= {STAGES{RESET_VAL}};
      vld  <= '0;
    end else begin
      data <= data_nxt;
      vld  <= vld_nxt;
    end
  end

  assign bus.q  = data[STAGES-1];
  assign bus.vo = vld[STAGES-1];
  assign bus.so = vld[STAGES-1];

endmodule

// File: tb/tb_dffq_scan_pipe.sv
// Directed bench for dffq_scan_pipe: an 8-bit 3-stage build (reset A5) and a
// 1-bit 1-stage corner build (reset 1), checked with immediate assertions.
module tb_dffq_scan_pipe;

  localparam int L = 27;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dffq_scan_pipe_if #(.WIDTH(8)) a_if ();
  dffq_scan_pipe_if #(.WIDTH(1)) b_if ();

  dffq_scan_pipe #(.WIDTH(8), .STAGES(3), .RESET_VAL(8'hA5)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  dffq_scan_pipe #(.WIDTH(1), .STAGES(1), .RESET_VAL(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic clr, input logic vi, input logic [7:0] d);
    a_if.en  = en;
    a_if.clr = clr;
    a_if.vi  = vi;
    a_if.d   = d;
  endtask

  task automatic check_a(input string tag, input logic [7:0] q, input logic vo);
    check({tag, ".q"},  32'(a_if.q),  32'(q));
    check({tag, ".vo"}, 32'(a_if.vo), 32'(vo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [L-1:0] img;
    logic [7:0]   exp_q;
    img = 27'h5A3C96F;

    drive_a(1'b0, 1'b0, 1'b0, 8'h00);
    a_if.se = 1'b0;
    a_if.si = 1'b0;
    b_if.en = 1'b0; b_if.clr = 1'b0; b_if.vi = 1'b0; b_if.d = 1'b0;
    b_if.se = 1'b0; b_if.si = 1'b0;

    // Reset state
    tick(); tick();
    check_a("rst", 8'hA5, 1'b0);
    check("rst.so", 32'(a_if.so), 32'd0);
    check("b_rst.q", 32'(b_if.q), 32'd1);
    rst = 1'b0;
    tick();
    check_a("post_rst_hold", 8'hA5, 1'b0);

    // Latency: 11/22/33 reach Q on edges 3,4,5
    drive_a(1'b1, 1'b0, 1'b1, 8'h11); tick(); check_a("lat_e1", 8'hA5, 1'b0);
    drive_a(1'b1, 1'b0, 1'b1, 8'h22); tick(); check_a("lat_e2", 8'hA5, 1'b0);
    drive_a(1'b1, 1'b0, 1'b1, 8'h33); tick(); check_a("lat_e3", 8'h11, 1'b1);
    drive_a(1'b1, 1'b0, 1'b0, 8'h00); tick(); check_a("lat_e4", 8'h22, 1'b1);
    tick(); check_a("lat_e5", 8'h33, 1'b1);

    // Stall with 11 in the middle stage
    drive_a(1'b1, 1'b0, 1'b1, 8'h77); tick(); check_a("fill_77", 8'h00, 1'b0);
    drive_a(1'b1, 1'b0, 1'b1, 8'h11); tick(); check_a("fill_11", 8'h00, 1'b0);
    drive_a(1'b1, 1'b0, 1'b1, 8'h55); tick(); check_a("fill_55", 8'h77, 1'b1);
    drive_a(1'b0, 1'b0, 1'b0, 8'hEE);
    for (int i = 0; i < 4; i++) begin
      tick(); check_a($sformatf("stall_%0d", i), 8'h77, 1'b1);
    end
    drive_a(1'b1, 1'b0, 1'b1, 8'h66); tick(); check_a("resume", 8'h11, 1'b1);

    // Clear with advance: pipe holds 66/55/11, all valid
    drive_a(1'b1, 1'b1, 1'b1, 8'h44); tick(); check_a("clr", 8'h55, 1'b0);
    drive_a(1'b1, 1'b0, 1'b0, 8'h99); tick(); check_a("clr_p1", 8'h66, 1'b0);
    tick(); check_a("clr_p2", 8'h44, 1'b0);

    // Asynchronous reset mid-cycle with a full valid pipe
    drive_a(1'b1, 1'b0, 1'b1, 8'h01); tick();
    drive_a(1'b1, 1'b0, 1'b1, 8'h02); tick();
    drive_a(1'b1, 1'b0, 1'b1, 8'h03); tick(); check_a("full", 8'h01, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_a("async_rst", 8'hA5, 1'b0);
    check("async_rst.so", 32'(a_if.so), 32'd0);
    tick(); check_a("rst_held", 8'hA5, 1'b0);
    rst = 1'b0;
    drive_a(1'b0, 1'b0, 1'b1, 8'hC3);
    tick(); check_a("rst_release", 8'hA5, 1'b0);

    // Scan with en/clr asserted (ignored): flush zeros, then a single 1
    drive_a(1'b1, 1'b1, 1'b1, 8'hFF);
    a_if.se = 1'b1;
    a_if.si = 1'b0;
    for (int e = 0; e < L; e++) tick();
    check("flush.so", 32'(a_if.so), 32'd0);
    for (int e = 1; e <= L; e++) begin
      a_if.si = (e == 1);
      tick();
      check($sformatf("pulse_e%0d", e), 32'(a_if.so), 32'(e == L));
    end
    check("scan_prio.vo", 32'(a_if.vo), 32'd1);

    // Shift a known image in, check parallel view, then shift it out
    for (int e = 0; e < L; e++) begin
      a_if.si = img[e];
      tick();
    end
    for (int i = 0; i < 8; i++) exp_q[i] = img[8-i];
    check("img.q", 32'(a_if.q), 32'(exp_q));
    a_if.si = 1'b0;
    for (int j = 0; j < L; j++) begin
      check($sformatf("img_out_%0d", j), 32'(a_if.so), 32'(img[j]));
      tick();
    end
    a_if.se = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0, 8'h00);

    // STAGES=1, WIDTH=1 corner build
    b_if.en = 1'b1; b_if.vi = 1'b1; b_if.d = 1'b0;
    tick(); check("b_lat1.q", 32'(b_if.q), 32'd0); check("b_lat1.vo", 32'(b_if.vo), 32'd1);
    b_if.vi = 1'b0; b_if.d = 1'b1;
    tick(); check("b_lat2.q", 32'(b_if.q), 32'd1); check("b_lat2.vo", 32'(b_if.vo), 32'd0);
    b_if.se = 1'b1; b_if.si = 1'b0;
    tick(); tick();
    check("b_flush.so", 32'(b_if.so), 32'd0);
    b_if.si = 1'b1;
    tick(); check("b_scan_e1.so", 32'(b_if.so), 32'd0);
    b_if.si = 1'b0;
    tick(); check("b_scan_e2.so", 32'(b_if.so), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
